// File: rtl/multi_ir_proximity.sv
// Multi-channel IR proximity front end: synchronise, debounce and edge-detect each sensor,
// then summarise presence and latch rising edges until acknowledged.
module multi_ir_proximity #(
  parameter int CHANNELS   = 4,
  parameter int COUNT      = 5,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CHANNELS-1:0]           sensor_i,
  input  logic [CHANNELS-1:0]           enable_i,
  input  logic                          ack_i,
  output logic [CHANNELS-1:0]           object,
  output logic [CHANNELS-1:0]           rise_o,
  output logic [CHANNELS-1:0]           fall_o,
  output logic                          any_o,
  output logic [$clog2(CHANNELS+1)-1:0] count_o,
  output logic                          event_o,
  output logic [CHANNELS-1:0]           pending_o
);

  localparam int CW = $clog2(COUNT + 1);
  localparam int NW = $clog2(CHANNELS + 1);
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);
  // Raw level that corresponds to "no object", so reset never looks like a detection.
  localparam logic [CHANNELS-1:0] IDLE_LEVEL = {CHANNELS{ACTIVE_LOW}};

  logic [CHANNELS-1:0] sync1_q, sync2_q;
  logic [CHANNELS-1:0] s;
  logic [CW-1:0]       cnt_q [CHANNELS];
  logic [CW-1:0]       cnt_d [CHANNELS];
  logic [CHANNELS-1:0] object_q, object_d;
  logic [CHANNELS-1:0] rise_q, rise_d;
  logic [CHANNELS-1:0] fall_q, fall_d;
  logic [CHANNELS-1:0] pending_q, pending_d;

  always_comb begin
    s        = sync2_q ^ IDLE_LEVEL;
    cnt_d    = cnt_q;
    object_d = object_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!enable_i[i]) begin
        cnt_d[i]    = '0;
        object_d[i] = 1'b0;
      end else if (s[i] == object_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == LAST) begin
        object_d[i] = s[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    rise_d    = object_d & ~object_q;
    fall_d    = ~object_d & object_q;
    // A rise on the acknowledge edge must survive the clear.
    pending_d = (ack_i ? '0 : pending_q) | rise_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= IDLE_LEVEL;
      sync2_q   <= IDLE_LEVEL;
      object_q  <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      pending_q <= '0;
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= sensor_i;
      sync2_q   <= sync1_q;
      object_q  <= object_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      pending_q <= pending_d;
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    count_o = '0;
    for (int i = 0; i < CHANNELS; i++) count_o = count_o + NW'(object_q[i]);
  end

  assign object    = object_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
  assign pending_o = pending_q;
  assign any_o     = |object_q;
  assign event_o   = |pending_q;

endmodule

// File: doc/multi_ir_proximity.md
MULTI_IR_PROXIMITY -- requirements
Module: multi_ir_proximity

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent IR sensor channels (1..16).
REQ-002 SHALL have parameter COUNT, default 5, debounce length in clock cycles (>=1).
REQ-003 SHALL have parameter ACTIVE_LOW, default 0; when 1, raw sensor level 0 means object present.
REQ-004 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port sensor_i  input  CHANNELS  raw asynchronous sensor levels.
REQ-007 SHALL have port enable_i  input  CHANNELS  per-channel enable.
REQ-008 SHALL have port ack_i  input  1  clears the event latch.
REQ-009 SHALL have port object  output  CHANNELS  debounced presence, 1 = object.
REQ-010 SHALL have port rise_o  output  CHANNELS  one-cycle pulse on object 0->1.
REQ-011 SHALL have port fall_o  output  CHANNELS  one-cycle pulse on object 1->0.
REQ-012 SHALL have port any_o  output  1  OR of object.
REQ-013 SHALL have port count_o  output  $clog2(CHANNELS+1)  number of object bits set.
REQ-014 SHALL have port event_o  output  1  sticky flag, some channel rose since last ack.
REQ-015 SHALL have port pending_o  output  CHANNELS  sticky mask of channels that rose since last ack.

Function
REQ-016 Each sensor_i bit SHALL pass a 2-flop synchronizer, then be inverted if ACTIVE_LOW=1, giving s[i].
REQ-017 Per channel, a counter of width $clog2(COUNT+1) SHALL clear on any edge where s[i]==object[i].
REQ-018 On an edge where s[i]!=object[i] and counter<COUNT-1, counter SHALL increment.
REQ-019 On an edge where s[i]!=object[i] and counter==COUNT-1, object[i] SHALL take s[i] and counter SHALL clear.
REQ-020 Latency: sensor_i stable from sampling edge k -> object changes at edge k+COUNT+1; COUNT=1 gives edge k+2.
REQ-021 A glitch on s[i] lasting fewer than COUNT cycles SHALL NOT change object[i] and SHALL reset the count.
REQ-022 enable_i[i]=0 SHALL clear counter[i] and force object[i] to 0 on the next edge; synchronizer keeps running.
REQ-023 Forced clearing by disable SHALL generate fall_o[i] if object[i] was 1; re-enable restarts debounce from count 0.
REQ-024 rise_o/fall_o SHALL be registered, asserted for exactly the one cycle following the object transition edge (same edge object updates).
REQ-025 any_o and count_o SHALL be pure combinational functions of the object register, zero-extended popcount.
REQ-026 pending_o[i] SHALL set on the edge rise_o[i] is generated; event_o SHALL equal |pending_o.
REQ-027 ack_i=1 SHALL clear pending_o on the next edge, except bits whose rise occurs that same edge, which SHALL remain set (set wins).
REQ-028 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL all be reported in the same cycle.

Reset
REQ-029 rst=1 SHALL immediately clear synchronizers, counters, object, rise_o, fall_o, pending_o; any_o=0, count_o=0, event_o=0.
REQ-030 Synchronizer reset value SHALL be the inactive level (0 after polarity), so no spurious rise after reset release.
REQ-031 Reset asserted mid-debounce SHALL discard the partial count; no fall_o pulse SHALL be produced by reset.

Verification (CHANNELS=4, COUNT=5, ACTIVE_LOW=0, 20 ns clock)
REQ-032 Release rst, enable_i=4'hF, sensor_i[0]=1 held -> object=4'h1 exactly 6 edges after first sample, rise_o[0] one cycle, count_o=1, event_o=1.
REQ-033 sensor_i[1] high for 3 cycles then low -> object[1] stays 0, no rise_o, count_o unchanged.
REQ-034 sensor_i=4'hF simultaneously -> object=4'hF same edge, rise_o=4'hF one cycle, count_o=4, pending_o=4'hF; ack_i pulse -> pending_o=0, event_o=0.
REQ-035 object[2]=1, enable_i[2]->0 -> object[2]=0 next edge with fall_o[2] pulse; re-enable with sensor high -> rise after full 5-cycle debounce.
REQ-036 ack_i=1 on the same edge as rise_o[3] -> pending_o[3]=1, event_o stays 1; rst asserted mid-debounce -> all outputs 0 asynchronously, no pulses on release.
